// File: rtl/bus_arb_pkg.sv
// Shared constants and types for the four-way round-robin bus arbiter.
package bus_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  // After reset the pointer sits on the last index so requester 0 wins first.
  localparam logic [SEL_W-1:0] LAST_RST = 2'd3;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_t;

  function automatic logic [NUM_REQ-1:0] idx_to_onehot(input logic [SEL_W-1:0] idx);
    return NUM_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/bus_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible request after last, modulo NUM_REQ.
module rr_pick
  import bus_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig_i,
  input  logic [SEL_W-1:0]   last_i,
  output logic [SEL_W-1:0]   idx_o,
  output logic               vld_o
);

  logic [SEL_W-1:0] cand;

  // Walk from furthest to nearest so the nearest eligible index is written last.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    cand  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = last_i + SEL_W'(k);
      if (elig_i[cand]) begin
        idx_o = cand;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin owner of the shared bus select; grants are held until released.
// Optional grant watchdog compiled in with `define BUS_ARB_TIMEOUT_EN.
module bus_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [SEL_W-1:0]   sel,
  output logic               busy,
  output logic               timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("bus_rr_arbiter: MAX_HOLD must lie in 2..255");
  end

  arb_state_t         state_q, state_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               busy_q, busy_d;

  logic [NUM_REQ-1:0] elig;
  logic [SEL_W-1:0]   pick_idx;
  logic               pick_vld;
  logic               hold_expired;

`ifdef BUS_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0]         hold_q, hold_d;
  logic [NUM_REQ-1:0] mask_q, mask_d;
  logic               timeout_q, timeout_d;

  assign elig         = req & ~mask_q;
  assign hold_expired = (hold_q == HOLD_LAST);
  assign timeout      = timeout_q;
`else
  assign elig         = req;
  assign hold_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

  rr_pick u_pick (
    .elig_i (elig),
    .last_i (last_q),
    .idx_o  (pick_idx),
    .vld_o  (pick_vld)
  );

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    busy_d  = busy_q;
`ifdef BUS_ARB_TIMEOUT_EN
    hold_d    = hold_q;
    mask_d    = mask_q & req;
    timeout_d = 1'b0;
`endif
    case (state_q)
      ARB_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_vld) begin
          gnt_d   = idx_to_onehot(pick_idx);
          sel_d   = pick_idx;
          busy_d  = 1'b1;
          last_d  = pick_idx;
          state_d = ARB_GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
          hold_d  = '0;
`endif
        end
      end
      ARB_GRANT: begin
        if (!req[sel_q] || hold_expired) begin
          gnt_d   = '0;
          busy_d  = 1'b0;
          state_d = ARB_IDLE;
`ifdef BUS_ARB_TIMEOUT_EN
          // Owner still requesting means the watchdog revoked it; bar it until it lets go.
          if (req[sel_q]) begin
            timeout_d      = 1'b1;
            mask_d[sel_q]  = 1'b1;
          end
`endif
        end
`ifdef BUS_ARB_TIMEOUT_EN
        else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      last_q  <= LAST_RST;
      gnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
    end
  end

`ifdef BUS_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      mask_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      mask_q    <= mask_d;
      timeout_q <= timeout_d;
    end
  end
`endif

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: doc/bus_rr_arbiter.md
# bus_rr_arbiter

Round-robin arbiter that owns the 2-bit bus select. Four requesters compete for one shared bus. The arbiter grants exactly one of them at a time, and its registered `sel` directly drives the select input of the downstream 4:1 read mux and the 2-to-4 bus enable decoder. A grant is held until the owner releases its request; an optional watchdog can force release.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum grant length in cycles when the watchdog is compiled in; legal range 2..255.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `req`  in  4: level request, one bit per requester; the owner keeps its bit high for as long as it uses the bus.
- `gnt`  out  4: registered one-hot grant; all zero when no owner.
- `sel`  out  2: registered binary index of the current or most recent owner; feeds the mux and decoder select.
- `busy`  out  1: registered; high while any grant is active.
- `timeout`  out  1: one-cycle pulse when the watchdog revokes a grant; tied 0 when the watchdog is compiled out.

## Operation
- State machine `IDLE`/`GRANT`, plus `last`, a 2-bit pointer to the most recently granted index.
- IDLE:
  - If any eligible `req` bit is set, pick the first set bit searching `last+1, last+2, …` modulo 4.
  - Register `gnt` to its one-hot code and `sel` to its index, set `busy`, load `last` with the index, and move to GRANT.
  - Otherwise stay in IDLE with `gnt=0` and `busy=0`. `sel` holds its previous value so the downstream select does not glitch.
- GRANT:
  - While `req[sel]` is 1, hold `gnt`, `sel` and `busy` unchanged. Other requests are ignored.
  - When `req[sel]` is 0, clear `gnt` and `busy` and go to IDLE. Re-arbitration happens in IDLE, so there is one dead cycle between owners.
- Eligibility: every `req` bit is eligible unless it is masked by the watchdog (see Configuration).
- Round-robin guarantees that with all four requesting continuously, grants rotate 0,1,2,3,0,…
- Reset values: `gnt=4'b0000`, `sel=2'b00`, `busy=0`, `timeout=0`, state IDLE, `last=2'd3` (so req0 has first priority), hold counter 0, mask 0.
- Reset asserted mid-grant clears all state and outputs immediately, without waiting for a clock edge.

## Timing
- `req` rising in cycle N while IDLE → `gnt`/`sel`/`busy` valid from edge N+1.
- Owner drops `req` in cycle M → `gnt` clears at edge M+1. The next grant, if any request is pending, appears at edge M+2.
- If the owner drops and re-raises its request within one dead cycle, it competes normally. Because `last` points to it, it has the lowest priority.
- A request bit that pulses high in a cycle when the arbiter is not in IDLE is not latched. Requesters must hold `req` until granted.
- `sel` never changes while `busy` is high.

## Configuration
Macro: `BUS_ARB_TIMEOUT_EN`.
- Defined:
  - An 8-bit hold counter clears on grant issue and increments on every GRANT cycle.
  - When the count reaches `MAX_HOLD-1` and `req[sel]` is still high, `gnt` and `busy` clear on the next edge, `timeout` pulses high for that one cycle, and the state returns to IDLE.
  - The revoked index's bit is set in a 4-bit mask, which makes it ineligible. The mask bit clears once that `req` bit is observed low.
  - A grant therefore lasts at most `MAX_HOLD` cycles.
- Undefined: no counter or mask is built, `timeout` is constant 0, and a grant lasts until release.

## Structure
- Shared package `bus_arb_pkg`: `NUM_REQ=4`, `SEL_W=2`, state enum `arb_state_t {ARB_IDLE, ARB_GRANT}`, and the reset value of `last`.
- One sub-module, `rr_pick`: combinational; inputs are the 4-bit eligible request vector and the 2-bit `last`; outputs are the 2-bit index and a valid flag. The top level holds all registers.

## Test plan
- Reset release with `req=4'b0000` for 5 cycles → `gnt=0`, `sel=0`, `busy=0` throughout.
- `req=4'b1111` held; each owner holds its grant for 3 cycles and then drops and re-raises its request → grant order 0,1,2,3,0, with one idle cycle between grants.
- `req=4'b0100` raised at cycle 10 → `gnt=4'b0100`, `sel=2'b10`, `busy=1` at edge 11. Drop the request at cycle 20 → `gnt=0` at edge 21, and `sel` stays `2'b10`.
- During a grant to index 1, raise `req[3]` → no change until req1 drops. At that point `gnt=4'b1000` appears 2 edges after the drop.
- Assert `rst_n=0` mid-grant between clock edges → `gnt`, `busy` and `sel` go to 0 immediately. After release, arbitration starts from index 0.
- With `BUS_ARB_TIMEOUT_EN` defined and `MAX_HOLD=4`, hold `req=4'b0011` → req0 is granted for 4 cycles, `timeout` pulses, and req1 is granted next. req0 is not re-granted until it deasserts its request.
